dc1_pbit_array: RTL and testbench

//  Parametrised per-line protection-bit (pbit) array for the L1 data cache.
//  Two banks (even/odd), N read ports, two bit-granular write ports and one whole-line insert port.

---
 rtl/dc1_pbit_array.sv | 113 +++++++++++
 tb/tb_dc1_pbit_array.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dc1_pbit_array.sv
// dc1_pbit_array: per-line protection-bit array for the L1 dcache.
// Even/odd banks, READ_PORTS read ports, two bit-write ports, one line-insert
// port. Writes go through a two-stage latch/merge pipeline; a clear sweep
// wipes the whole array after reset and on flush.
module dc1_pbit_array #(
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 4,
  parameter int LINE_BITS  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORTS-1:0]                 rd_en,
  input  logic [READ_PORTS*(ADDR_WIDTH+4)-1:0]  rd_addr,
  input  logic [READ_PORTS-1:0]                 rd_odd,
  output logic [READ_PORTS-1:0]                 rd_pbit,
  input  logic                                  wr0_en,
  input  logic [ADDR_WIDTH+3:0]                 wr0_addr,
  input  logic                                  wr0_odd,
  input  logic                                  wr0_pbit,
  input  logic                                  wr1_en,
  input  logic [ADDR_WIDTH+3:0]                 wr1_addr,
  input  logic                                  wr1_odd,
  input  logic                                  wr1_pbit,
  input  logic                                  ins_en,
  input  logic [ADDR_WIDTH-1:0]                 ins_addr,
  input  logic                                  ins_odd,
  input  logic [LINE_BITS-1:0]                  ins_data,
  input  logic                                  flush_req,
  output logic                                  busy
);
  localparam int AW = ADDR_WIDTH + 4;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  typedef struct packed {
    logic          en;
    logic          odd;
    logic [AW-1:0] addr;
    logic          pbit;
  } bit_req_t;

  typedef struct packed {
    logic                  en;
    logic                  odd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_BITS-1:0]  data;
  } line_req_t;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  bit_req_t              w0_q, w1_q;
  line_req_t             ins_q;
  logic [1:0][2**ADDR_WIDTH-1:0][LINE_BITS-1:0] mem, mem_nxt;

  assign busy = (state == ST_SWEEP);

  // Sweep FSM: walk idx across all entries, then idle until a flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_SWEEP;
      idx   <= '0;
    end else if (state == ST_SWEEP) begin
      idx <= idx + 1'b1;
      if (&idx) state <= ST_IDLE;
    end else if (flush_req) begin
      state <= ST_SWEEP;
      idx   <= '0;
    end
  end

  // W1: latch requests; dropped while sweeping. An insert kills wr1 outright.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w0_q.en  <= 1'b0;
      w1_q.en  <= 1'b0;
      ins_q.en <= 1'b0;
    end else begin
      w0_q  <= '{en: wr0_en && !busy, odd: wr0_odd, addr: wr0_addr, pbit: wr0_pbit};
      w1_q  <= '{en: wr1_en && !ins_en && !busy, odd: wr1_odd, addr: wr1_addr, pbit: wr1_pbit};
      ins_q <= '{en: ins_en && !busy, odd: ins_odd, addr: ins_addr, data: ins_data};
    end
  end

  // W2 merge: ins line, then wr0 bit, then wr1 bit; the sweep clear lands last
  // so it overrides a commit to the same entry. Old values come straight from
  // the array, which already holds the previous cycle's commit.
  always_comb begin
    mem_nxt = mem;
    if (ins_q.en) mem_nxt[ins_q.odd][ins_q.addr] = ins_q.data;
    if (w0_q.en)  mem_nxt[w0_q.odd][w0_q.addr[AW-1:4]][w0_q.addr[3:0]] = w0_q.pbit;
    if (w1_q.en)  mem_nxt[w1_q.odd][w1_q.addr[AW-1:4]][w1_q.addr[3:0]] = w1_q.pbit;
    if (state == ST_SWEEP) begin
      mem_nxt[0][idx] = '0;
      mem_nxt[1][idx] = '0;
    end
  end

  // Array commit; a reset cycle aborts whatever sits in W2
  always_ff @(posedge clk) begin
    if (rst) mem <= mem_nxt;
  end

  // Reads see the post-merge view, so writes already in W2 are forwarded
  always_ff @(posedge clk) begin
    for (int p = 0; p < READ_PORTS; p++) begin
      if (!rst || busy)
        rd_pbit[p] <= 1'b0;
      else if (rd_en[p])
        rd_pbit[p] <= mem_nxt[rd_odd[p]][rd_addr[p*AW+4 +: ADDR_WIDTH]][rd_addr[p*AW +: 4]];
    end
  end

endmodule

// File: tb/tb_dc1_pbit_array.sv
// Scoreboard bench for dc1_pbit_array: the driver updates a line-level model
// each cycle and queues expected rd_pbit/busy; the monitor checks them after
// the closing edge of that cycle.
module tb_dc1_pbit_array;
  localparam int AWD = 5;
  localparam int NP  = 4;
  localparam int AW  = AWD + 4;
  localparam int NE  = 32;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    rd_en, rd_odd, rd_pbit;
  logic [NP*AW-1:0] rd_addr;
  logic wr0_en, wr0_odd, wr0_pbit, wr1_en, wr1_odd, wr1_pbit;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic ins_en, ins_odd, flush_req, busy;
  logic [AWD-1:0] ins_addr;
  logic [15:0] ins_data;

  dc1_pbit_array #(.ADDR_WIDTH(AWD), .READ_PORTS(NP), .LINE_BITS(16)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_odd(rd_odd),
    .rd_pbit(rd_pbit), .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_odd(wr0_odd),
    .wr0_pbit(wr0_pbit), .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_odd(wr1_odd),
    .wr1_pbit(wr1_pbit), .ins_en(ins_en), .ins_addr(ins_addr), .ins_odd(ins_odd),
    .ins_data(ins_data), .flush_req(flush_req), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NP-1:0] rd;
    logic          bz;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: lines per bank, sweep position, last cycle's writes
  logic [15:0] m [2][NE];
  bit sw = 1'b1;
  int sidx = 0;
  logic [NP-1:0] exp_rd = '0;
  bit pv = 1'b0;
  logic p_ins_en, p_ins_odd, p_w0_en, p_w0_odd, p_w0_v, p_w1_en, p_w1_odd, p_w1_v;
  int p_ins_e, p_w0_e, p_w0_b, p_w1_e, p_w1_b;
  logic [15:0] p_ins_d;

  task automatic clear_inputs();
    rd_en = '0; rd_addr = '0; rd_odd = '0;
    wr0_en = 0; wr0_addr = '0; wr0_odd = 0; wr0_pbit = 0;
    wr1_en = 0; wr1_addr = '0; wr1_odd = 0; wr1_pbit = 0;
    ins_en = 0; ins_addr = '0; ins_odd = 0; ins_data = '0;
    flush_req = 0;
  endtask

  task automatic set_rd(input int p, input int e, input int b, input logic odd);
    logic [AW-1:0] a;
    a = {e[AWD-1:0], b[3:0]};
    rd_en[p] = 1'b1;
    rd_odd[p] = odd;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int port, input int e, input int b, input logic odd, input logic v);
    logic [AW-1:0] a;
    a = {e[AWD-1:0], b[3:0]};
    if (port == 0) begin wr0_en = 1; wr0_addr = a; wr0_odd = odd; wr0_pbit = v; end
    else           begin wr1_en = 1; wr1_addr = a; wr1_odd = odd; wr1_pbit = v; end
  endtask

  // Evaluate one cycle of the model on the current inputs, queue the
  // expectation, then advance to just after the next rising edge.
  task automatic tick();
    exp_t ex;
    if (!rst) begin
      exp_rd = '0; sw = 1'b1; sidx = 0; pv = 1'b0;
    end else begin
      if (pv) begin
        if (p_ins_en) m[p_ins_odd][p_ins_e] = p_ins_d;
        if (p_w0_en)  m[p_w0_odd][p_w0_e][p_w0_b] = p_w0_v;
        if (p_w1_en && !p_ins_en) m[p_w1_odd][p_w1_e][p_w1_b] = p_w1_v;
      end
      if (sw) begin m[0][sidx] = '0; m[1][sidx] = '0; end
      for (int p = 0; p < NP; p++) begin
        if (sw) exp_rd[p] = 1'b0;
        else if (rd_en[p])
          exp_rd[p] = m[rd_odd[p]][int'(rd_addr[p*AW+4 +: AWD])][int'(rd_addr[p*AW +: 4])];
      end
      pv = !sw;
      p_ins_en = ins_en; p_ins_odd = ins_odd; p_ins_e = int'(ins_addr); p_ins_d = ins_data;
      p_w0_en = wr0_en; p_w0_odd = wr0_odd; p_w0_e = int'(wr0_addr[AW-1:4]);
      p_w0_b = int'(wr0_addr[3:0]); p_w0_v = wr0_pbit;
      p_w1_en = wr1_en; p_w1_odd = wr1_odd; p_w1_e = int'(wr1_addr[AW-1:4]);
      p_w1_b = int'(wr1_addr[3:0]); p_w1_v = wr1_pbit;
      if (sw) begin
        if (sidx == NE - 1) sw = 1'b0;
        sidx = (sidx + 1) % NE;
      end else if (flush_req) begin
        sw = 1'b1; sidx = 0;
      end
    end
    ex.cyc = cyc; ex.rd = exp_rd; ex.bz = sw;
    q.push_back(ex);
    @(posedge clk); #1;
  endtask

  // Monitor: once the cycle an expectation belongs to has closed, compare
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t ex;
      ex = q.pop_front();
      n_chk++;
      if (rd_pbit === ex.rd) n_pass++;
      else $display("FAIL rd_pbit cyc=%0d got=%b exp=%b", ex.cyc, rd_pbit, ex.rd);
      n_chk++;
      if (busy === ex.bz) n_pass++;
      else $display("FAIL busy cyc=%0d got=%b exp=%b", ex.cyc, busy, ex.bz);
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    // reset release: busy for 32 cycles, reads return 0
    for (int i = 0; i < 36; i++) begin
      clear_inputs();
      for (int p = 0; p < NP; p++) set_rd(p, $urandom_range(0, NE-1), $urandom_range(0, 15), 1'($urandom));
      tick();
    end
    // two bit writes to one entry in the same cycle
    clear_inputs(); set_wr(0, 3, 2, 0, 1); set_wr(1, 3, 5, 0, 1); tick();
    clear_inputs(); tick();
    clear_inputs(); set_rd(0, 3, 2, 0); set_rd(1, 3, 5, 0); set_rd(2, 3, 3, 0); tick();
    // insert plus bit writes: wr0 merges, wr1 suppressed
    clear_inputs(); ins_en = 1; ins_addr = 7; ins_odd = 1; ins_data = 16'hFFFF;
    set_wr(0, 7, 0, 1, 0); set_wr(1, 7, 1, 1, 0); tick();
    clear_inputs(); tick();
    clear_inputs(); set_rd(0, 7, 0, 1); set_rd(1, 7, 1, 1); set_rd(2, 7, 15, 1); tick();
    // read-after-write latency
    clear_inputs(); set_wr(0, 9, 4, 0, 1); set_rd(0, 9, 4, 0); tick();
    clear_inputs(); set_rd(0, 9, 4, 0); tick();
    clear_inputs(); tick();
    // flush wipes the array; writes issued during the sweep are lost
    clear_inputs(); set_wr(0, 0, 0, 0, 1); tick();
    clear_inputs(); flush_req = 1; tick();
    for (int i = 0; i < 34; i++) begin
      clear_inputs(); set_rd(0, 0, 0, 0); flush_req = (i == 5);
      if (i == 3) set_wr(1, 5, 1, 0, 1);
      tick();
    end
    clear_inputs(); set_rd(0, 0, 0, 0); set_rd(1, 5, 1, 0); tick();
    // reset mid-sweep with a write still in W2
    clear_inputs(); flush_req = 1; set_wr(0, 12, 3, 1, 1); tick();
    clear_inputs(); rst = 1'b0; tick();
    rst = 1'b1;
    for (int i = 0; i < 34; i++) begin clear_inputs(); set_rd(0, 12, 3, 1); tick(); end
    // randomized traffic concentrated on a few entries
    for (int i = 0; i < 900; i++) begin
      clear_inputs();
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) != 0) set_rd(p, $urandom_range(0, 5), $urandom_range(0, 15), 1'($urandom));
      if ($urandom_range(0, 1)) set_wr(0, $urandom_range(0, 5), $urandom_range(0, 15), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1)) set_wr(1, $urandom_range(0, 5), $urandom_range(0, 15), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        ins_en = 1; ins_addr = 5'($urandom_range(0, 5)); ins_odd = 1'($urandom); ins_data = 16'($urandom);
      end
      flush_req = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst = 1'b1;
    clear_inputs(); tick(); tick();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
